// File: rtl/clkdiv_pkg.sv
// Shared defaults, index-width helper and per-channel state layout for clk_divider_prog.
package clkdiv_pkg;

  localparam int CNT_W_DEF   = 16;
  localparam int DEF_DIV_DEF = 25000;

  function automatic int ch_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Layout at the default counter width; channels rebuild it at their own CNT_W.
  typedef struct packed {
    logic [CNT_W_DEF-1:0] cnt;
    logic [CNT_W_DEF-1:0] half;
    logic [CNT_W_DEF-1:0] shadow;
    logic                 pend;
  } ch_state_t;

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: counter, shadow/apply of the half-period, registered clkout/tick.
// CLKDIV_PHASE_SYNC_EN adds the sync input that restarts the channel phase-aligned.
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DEF_DIV = DEF_DIV_DEF
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
`ifdef CLKDIV_PHASE_SYNC_EN
  input  logic             sync,
`endif
  output logic             clkout,
  output logic             tick,
  output logic             pend
);

  typedef struct packed {
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] half;
    logic [CNT_W-1:0] shadow;
    logic             pend;
  } state_t;

  localparam logic [CNT_W-1:0] DEF_H = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t st;

  assign pend = st.pend;

  always_ff @(posedge clkin or negedge rst) begin
    if (!rst) begin
      st     <= '{cnt: '0, half: DEF_H, shadow: DEF_H, pend: 1'b0};
      clkout <= 1'b0;
      tick   <= 1'b0;
    end else begin
      tick <= 1'b0;
`ifdef CLKDIV_PHASE_SYNC_EN
      if (sync) begin
        st.cnt <= '0;
        clkout <= 1'b0;
        if (st.pend) begin
          st.half <= st.shadow;
          st.pend <= 1'b0;
        end
      end else
`endif
      if (st.half == '0) begin
        st.cnt <= '0;
        clkout <= 1'b0;
        if (st.pend) begin
          st.half <= st.shadow;
          st.pend <= 1'b0;
        end
      end else if (st.cnt == st.half - ONE) begin
        st.cnt <= '0;
        clkout <= ~clkout;
        tick   <= 1'b1;
        // New half-period only lands on the falling edge that closes a full period.
        if (clkout && st.pend) begin
          st.half <= st.shadow;
          st.pend <= 1'b0;
        end
      end else begin
        st.cnt <= st.cnt + ONE;
      end
      // Placed last so a same-edge write keeps pend set and lands in the shadow.
      if (wr) begin
        st.shadow <= wr_div;
        st.pend   <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/clk_divider_prog.sv
// Runtime-programmable multi-channel 50%-duty clock divider with per-channel tick strobes.
// CLKDIV_PHASE_SYNC_EN adds a sync input that realigns all channels.
module clk_divider_prog
  import clkdiv_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DEF_DIV = DEF_DIV_DEF
) (
  input  logic                      clkin,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [ch_w(NUM_CH)-1:0]   wr_ch,
  input  logic [CNT_W-1:0]          wr_div,
`ifdef CLKDIV_PHASE_SYNC_EN
  input  logic                      sync,
`endif
  output logic [NUM_CH-1:0]         clkout,
  output logic [NUM_CH-1:0]         tick,
  output logic [NUM_CH-1:0]         pend
);

  localparam int CH_W = ch_w(NUM_CH);

  logic [NUM_CH-1:0] wr_sel;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // Indices at or above NUM_CH match no channel, so such writes are dropped.
    assign wr_sel[i] = wr_en && (wr_ch == CH_W'(i));

    clkdiv_channel #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .clkin  (clkin),
      .rst    (rst),
      .wr     (wr_sel[i]),
      .wr_div (wr_div),
`ifdef CLKDIV_PHASE_SYNC_EN
      .sync   (sync),
`endif
      .clkout (clkout[i]),
      .tick   (tick[i]),
      .pend   (pend[i])
    );
  end

endmodule

// File: tb/tb_clk_divider_prog.sv
// Directed bench for clk_divider_prog (3 channels, DEF_DIV=3); sync scenario under CLKDIV_PHASE_SYNC_EN.
module tb_clk_divider_prog;

  localparam int NUM_CH  = 3;
  localparam int CNT_W   = 16;
  localparam int DEF_DIV = 3;

  logic              clkin;
  logic              rst;
  logic              wr_en;
  logic [1:0]        wr_ch;
  logic [CNT_W-1:0]  wr_div;
  logic              sync;
  logic [NUM_CH-1:0] clkout;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] pend;

  int n_checks = 0;
  int n_fail   = 0;

  // Channel 1 retime 3 -> 4 -> 2, edges 1..19
  bit rt_clk  [1:19] = '{0,0,1,1,1,0,0,0,0,1,1,1,1,0,0,1,1,0,0};
  bit rt_pend [1:19] = '{1,1,1,1,1,0,0,0,0,0,0,1,1,0,0,0,0,0,0};
  // Channel 2 stop then restart with 5, edges 1..24
  bit st_clk  [1:24] = '{0,0,1,1,1,0,0,0,0,0,0,0, 0,0,0,0,0,0,1,1,1,1,1,0};
  bit st_tick [1:24] = '{0,0,1,0,0,1,0,0,0,0,0,0, 0,0,0,0,0,0,1,0,0,0,0,1};
  bit st_pend [1:24] = '{1,1,1,1,1,0,0,0,0,0,0,0, 1,0,0,0,0,0,0,0,0,0,0,0};
  // Phase sync, edges 9..14
  logic [2:0] sy_clk  [9:14] = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b100, 3'b110};
  logic [2:0] sy_tick [9:14] = '{3'b000, 3'b000, 3'b001, 3'b000, 3'b101, 3'b010};

  clk_divider_prog #(
    .NUM_CH  (NUM_CH),
    .CNT_W   (CNT_W),
    .DEF_DIV (DEF_DIV)
  ) dut (
    .clkin  (clkin),
    .rst    (rst),
    .wr_en  (wr_en),
    .wr_ch  (wr_ch),
    .wr_div (wr_div),
`ifdef CLKDIV_PHASE_SYNC_EN
    .sync   (sync),
`endif
    .clkout (clkout),
    .tick   (tick),
    .pend   (pend)
  );

  initial begin
    clkin = 1'b0;
    forever #5 clkin = ~clkin;
  end

  task automatic step();
    @(posedge clkin);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_div = '0; sync = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_div = '0; sync = 1'b0;
    step();
    step();
    n_checks++;
    if ({clkout, tick, pend} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_state got clk=%b tick=%b pend=%b exp all 0", clkout, tick, pend);
    end
    rst = 1'b1;
  endtask

  task automatic test_default_divide();
    logic [2:0] ec, et;
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      step();
      ec = ((k / 3) % 2 == 1) ? 3'b111 : 3'b000;
      et = (k % 3 == 0) ? 3'b111 : 3'b000;
      n_checks++;
      if (clkout !== ec) begin
        n_fail++;
        $display("FAIL default_clk edge=%0d got %b exp %b", k, clkout, ec);
      end
      n_checks++;
      if (tick !== et) begin
        n_fail++;
        $display("FAIL default_tick edge=%0d got %b exp %b", k, tick, et);
      end
    end
  endtask

  task automatic test_retime();
    logic ec0;
    do_reset();
    for (int k = 1; k <= 19; k++) begin
      wr_en  = (k == 1) || (k == 12);
      wr_ch  = 2'd1;
      wr_div = (k == 1) ? 16'd4 : 16'd2;
      step();
      wr_en = 1'b0;
      ec0 = ((k / 3) % 2 == 1);
      n_checks++;
      if (clkout[1] !== rt_clk[k]) begin
        n_fail++;
        $display("FAIL retime_clk1 edge=%0d got %b exp %b", k, clkout[1], rt_clk[k]);
      end
      n_checks++;
      if (pend !== {1'b0, rt_pend[k], 1'b0}) begin
        n_fail++;
        $display("FAIL retime_pend edge=%0d got %b exp %b", k, pend, {1'b0, rt_pend[k], 1'b0});
      end
      n_checks++;
      if (clkout[0] !== ec0) begin
        n_fail++;
        $display("FAIL retime_clk0_undisturbed edge=%0d got %b exp %b", k, clkout[0], ec0);
      end
    end
  endtask

  task automatic test_stop_restart();
    do_reset();
    for (int k = 1; k <= 24; k++) begin
      wr_en  = (k == 1) || (k == 13);
      wr_ch  = 2'd2;
      wr_div = (k == 1) ? 16'd0 : 16'd5;
      step();
      wr_en = 1'b0;
      n_checks++;
      if (clkout[2] !== st_clk[k]) begin
        n_fail++;
        $display("FAIL stop_clk2 edge=%0d got %b exp %b", k, clkout[2], st_clk[k]);
      end
      n_checks++;
      if (tick[2] !== st_tick[k]) begin
        n_fail++;
        $display("FAIL stop_tick2 edge=%0d got %b exp %b", k, tick[2], st_tick[k]);
      end
      n_checks++;
      if (pend[2] !== st_pend[k]) begin
        n_fail++;
        $display("FAIL stop_pend2 edge=%0d got %b exp %b", k, pend[2], st_pend[k]);
      end
    end
  endtask

  task automatic test_last_write_wins();
    logic ec0, ep0;
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      wr_en  = (k <= 3);
      wr_ch  = (k == 3) ? 2'd3 : 2'd0;
      wr_div = (k == 1) ? 16'd7 : (k == 2) ? 16'd3 : 16'd9;
      step();
      wr_en = 1'b0;
      ec0 = ((k / 3) % 2 == 1);
      ep0 = (k <= 5);
      n_checks++;
      if (clkout[0] !== ec0) begin
        n_fail++;
        $display("FAIL lastwr_clk0 edge=%0d got %b exp %b", k, clkout[0], ec0);
      end
      n_checks++;
      if (pend !== {2'b00, ep0}) begin
        n_fail++;
        $display("FAIL lastwr_pend edge=%0d got %b exp %b", k, pend, {2'b00, ep0});
      end
    end
  endtask

  task automatic test_async_reset();
    logic [2:0] ec, et;
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      wr_en  = (k == 3);
      wr_ch  = 2'd1;
      wr_div = 16'd6;
      step();
      wr_en = 1'b0;
    end
    n_checks++;
    if ({clkout, tick, pend} !== {3'b111, 3'b111, 3'b010}) begin
      n_fail++;
      $display("FAIL areset_before got clk=%b tick=%b pend=%b exp 111 111 010", clkout, tick, pend);
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({clkout, tick, pend} !== 9'b0) begin
      n_fail++;
      $display("FAIL areset_immediate got clk=%b tick=%b pend=%b exp all 0", clkout, tick, pend);
    end
    step();
    step();
    n_checks++;
    if ({clkout, tick, pend} !== 9'b0) begin
      n_fail++;
      $display("FAIL areset_held got clk=%b tick=%b pend=%b exp all 0", clkout, tick, pend);
    end
    rst = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      ec = ((k / 3) % 2 == 1) ? 3'b111 : 3'b000;
      et = (k % 3 == 0) ? 3'b111 : 3'b000;
      n_checks++;
      if ({clkout, tick, pend} !== {ec, et, 3'b000}) begin
        n_fail++;
        $display("FAIL areset_restart edge=%0d got %b %b %b exp %b %b 000", k, clkout, tick, pend, ec, et);
      end
    end
  endtask

`ifdef CLKDIV_PHASE_SYNC_EN
  task automatic test_phase_sync();
    do_reset();
    for (int k = 1; k <= 14; k++) begin
      wr_en  = (k == 1) || (k == 2) || (k == 8);
      wr_ch  = (k == 1) ? 2'd0 : (k == 2) ? 2'd1 : 2'd2;
      wr_div = (k == 1) ? 16'd2 : (k == 2) ? 16'd5 : 16'd4;
      sync   = (k == 9);
      step();
      wr_en = 1'b0;
      sync  = 1'b0;
      if (k == 8) begin
        n_checks++;
        if ({clkout, pend} !== {3'b001, 3'b100}) begin
          n_fail++;
          $display("FAIL sync_before got clk=%b pend=%b exp 001 100", clkout, pend);
        end
      end
      if (k >= 9) begin
        n_checks++;
        if ({clkout, tick, pend} !== {sy_clk[k], sy_tick[k], 3'b000}) begin
          n_fail++;
          $display("FAIL sync_after edge=%0d got %b %b %b exp %b %b 000", k, clkout, tick, pend, sy_clk[k], sy_tick[k]);
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_default_divide();
    test_retime();
    test_stop_restart();
    test_last_write_wins();
    test_async_reset();
`ifdef CLKDIV_PHASE_SYNC_EN
    test_phase_sync();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
